// File: rtl/spi_rx_deserializer_pkg.sv
// Shared SPI definitions used by both the RX deserializer and the TX FSM.
// Holds the FSM state encoding, the byte width and the default FIFO depth.
package spi_rx_deserializer_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_rx_deserializer_if.sv
// Bundle of the SPI input pins and the host-side receive FIFO signals.
// The master modport is used by the driver side and the slave modport by the deserializer.
interface spi_rx_deserializer_if
  import spi_rx_deserializer_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic              SPI_clk;
  logic              SPI_CS;
  logic              SPI_MISO;
  logic              Read_RQ;
  logic              Ovf_Clr;
  logic [BYTE_W-1:0] Rx_Data;
  logic              Rx_Valid;
  logic              Rx_Empty;
  logic              Rx_Full;
  logic [ADDR_W:0]   Rx_Count;
  logic              Overflow;
  logic              Frame_Done;

  modport master (
    output SPI_clk, SPI_CS, SPI_MISO, Read_RQ, Ovf_Clr,
    input  Rx_Data, Rx_Valid, Rx_Empty, Rx_Full, Rx_Count, Overflow, Frame_Done
  );

  modport slave (
    input  SPI_clk, SPI_CS, SPI_MISO, Read_RQ, Ovf_Clr,
    output Rx_Data, Rx_Valid, Rx_Empty, Rx_Full, Rx_Count, Overflow, Frame_Done
  );

endinterface

// File: rtl/spi_rx_deserializer_rx_fifo.sv
// Synchronous byte FIFO with a registered pop port (data and valid one cycle after pop).
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module rx_fifo
  import spi_rx_deserializer_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] pushData_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] rdData_o,
  output logic              rdValid_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q;
  logic [ADDR_W-1:0] rdPtr_q;
  logic [ADDR_W:0]   count_q;
  logic [BYTE_W-1:0] rdData_q;
  logic              rdValid_q;
  logic              doPop;
  logic              doPush;

  assign doPop  = pop_i && (count_q != '0);
  assign doPush = push_i && ((count_q != FULL_CNT) || doPop);

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem[wrPtr_q] <= pushData_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= doPop;
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q  <= rdPtr_q + 1'b1;
        rdData_q <= mem[rdPtr_q];
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdData_o  = rdData_q;
  assign rdValid_o = rdValid_q;
  assign count_o   = count_q;
  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign drop_o    = push_i && !doPush;

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI receive path: synchronises the SPI pins into Mclk, shifts MISO in MSB first
// on each SPI_clk rise during a chip-select frame, and queues whole bytes for the host.
module spi_rx_deserializer
  import spi_rx_deserializer_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                  Mclk,
  input logic                  nReset,
  spi_rx_deserializer_if.slave bus
);

  logic [SYNC_STAGES-1:0] clkSync_q;
  logic [SYNC_STAGES-1:0] csSync_q;
  logic [SYNC_STAGES-1:0] misoSync_q;
  logic                   clkPrev_q;
  logic                   clkS;
  logic                   csS;
  logic                   misoS;
  logic                   spiRise;

  spi_state_e        state_q;
  logic [2:0]        bitCnt_q;
  logic [BYTE_W-1:0] shiftReg_q;
  logic [BYTE_W-1:0] shift_d;
  logic              pushValid_q;
  logic [BYTE_W-1:0] pushData_q;
  logic              frameDone_q;
  logic              overflow_q;
  logic              fifoDrop;

  // All three pins go through identical chains so MISO lines up with the clock edge.
  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      clkSync_q  <= '0;
      csSync_q   <= '0;
      misoSync_q <= '0;
      clkPrev_q  <= 1'b0;
    end else begin
      clkSync_q[0]  <= bus.SPI_clk;
      csSync_q[0]   <= bus.SPI_CS;
      misoSync_q[0] <= bus.SPI_MISO;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clkSync_q[i]  <= clkSync_q[i-1];
        csSync_q[i]   <= csSync_q[i-1];
        misoSync_q[i] <= misoSync_q[i-1];
      end
      clkPrev_q <= clkSync_q[SYNC_STAGES-1];
    end
  end

  assign clkS    = clkSync_q[SYNC_STAGES-1];
  assign csS     = csSync_q[SYNC_STAGES-1];
  assign misoS   = misoSync_q[SYNC_STAGES-1];
  assign spiRise = clkS && !clkPrev_q;
  assign shift_d = {shiftReg_q[BYTE_W-2:0], misoS};

  // A sample landing in the same cycle CS rises is still taken, so a byte
  // completed on that edge is pushed; a partial byte dies because entry clears bitCnt.
  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shiftReg_q  <= '0;
      pushValid_q <= 1'b0;
      pushData_q  <= '0;
      frameDone_q <= 1'b0;
    end else begin
      pushValid_q <= 1'b0;
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!csS) begin
            state_q  <= SHIFT;
            bitCnt_q <= '0;
          end
        end
        SHIFT: begin
          if (spiRise) begin
            shiftReg_q <= shift_d;
            bitCnt_q   <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              pushValid_q <= 1'b1;
              pushData_q  <= shift_d;
            end
          end
          if (csS) begin
            state_q     <= IDLE;
            frameDone_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rx_fifo (
    .clk_i      (Mclk),
    .rst_ni     (nReset),
    .push_i     (pushValid_q),
    .pushData_i (pushData_q),
    .pop_i      (bus.Read_RQ),
    .rdData_o   (bus.Rx_Data),
    .rdValid_o  (bus.Rx_Valid),
    .count_o    (bus.Rx_Count),
    .full_o     (bus.Rx_Full),
    .empty_o    (bus.Rx_Empty),
    .drop_o     (fifoDrop)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      overflow_q <= 1'b0;
    end else if (fifoDrop) begin
      overflow_q <= 1'b1;
    end else if (bus.Ovf_Clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.Overflow   = overflow_q;
  assign bus.Frame_Done = frameDone_q;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Directed bench for spi_rx_deserializer: drives SPI frames and host reads,
// and compares outputs against hand-computed values.
module tb_spi_rx_deserializer;

  logic Mclk;
  logic nReset;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   frameDoneCnt = 0;
  int   doneBase;

  spi_rx_deserializer_if #(.ADDR_W(4)) bus ();

  spi_rx_deserializer #(
    .DEPTH       (16),
    .ADDR_W      (4),
    .SYNC_STAGES (2)
  ) dut (
    .Mclk   (Mclk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial Mclk = 1'b0;
  always #5 Mclk = ~Mclk;

  always @(posedge Mclk) begin
    if (bus.Frame_Done === 1'b1) frameDoneCnt <= frameDoneCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // SPI_clk half period is 4 Mclk cycles; with popOnLast the host pops in the push cycle of the last bit.
  task automatic applyStimulus(input logic [7:0] data, input int nBits, input bit popOnLast);
    for (int i = 0; i < nBits; i++) begin
      bus.SPI_MISO = data[7-i];
      repeat (4) @(negedge Mclk);
      bus.SPI_clk = 1'b1;
      if (popOnLast && (i == nBits - 1)) begin
        repeat (3) @(negedge Mclk);
        bus.Read_RQ = 1'b1;
        @(negedge Mclk);
        bus.Read_RQ = 1'b0;
        checkOutput("fullPopValid", 32'(bus.Rx_Valid), 32'h1);
        checkOutput("fullPopData", 32'(bus.Rx_Data), 32'h20);
        checkOutput("fullPopCount", 32'(bus.Rx_Count), 32'd16);
        checkOutput("fullPopOverflow", 32'(bus.Overflow), 32'h0);
      end else begin
        repeat (4) @(negedge Mclk);
      end
      bus.SPI_clk = 1'b0;
    end
  endtask

  task automatic frameBegin();
    bus.SPI_CS = 1'b0;
    repeat (4) @(negedge Mclk);
  endtask

  task automatic frameEnd();
    repeat (4) @(negedge Mclk);
    bus.SPI_CS = 1'b1;
    repeat (8) @(negedge Mclk);
  endtask

  task automatic readByte(input string tag, input logic [7:0] expected);
    bus.Read_RQ = 1'b1;
    @(negedge Mclk);
    bus.Read_RQ = 1'b0;
    checkOutput({tag, "Valid"}, 32'(bus.Rx_Valid), 32'h1);
    checkOutput({tag, "Data"}, 32'(bus.Rx_Data), 32'(expected));
  endtask

  initial begin
    nReset       = 1'b0;
    bus.SPI_clk  = 1'b0;
    bus.SPI_CS   = 1'b1;
    bus.SPI_MISO = 1'b0;
    bus.Read_RQ  = 1'b0;
    bus.Ovf_Clr  = 1'b0;
    repeat (3) @(negedge Mclk);

    checkOutput("rstEmpty", 32'(bus.Rx_Empty), 32'h1);
    checkOutput("rstCount", 32'(bus.Rx_Count), 32'h0);
    checkOutput("rstValid", 32'(bus.Rx_Valid), 32'h0);
    checkOutput("rstFull", 32'(bus.Rx_Full), 32'h0);
    checkOutput("rstOverflow", 32'(bus.Overflow), 32'h0);
    checkOutput("rstFrameDone", 32'(bus.Frame_Done), 32'h0);
    checkOutput("rstData", 32'(bus.Rx_Data), 32'h0);

    nReset = 1'b1;
    repeat (10) @(negedge Mclk);

    // Single byte 0xA5
    doneBase = frameDoneCnt;
    frameBegin();
    applyStimulus(8'hA5, 8, 1'b0);
    frameEnd();
    checkOutput("singleCount", 32'(bus.Rx_Count), 32'd1);
    checkOutput("singleFrameDone", 32'(frameDoneCnt - doneBase), 32'd1);
    readByte("single", 8'hA5);
    checkOutput("singleEmptyAfter", 32'(bus.Rx_Empty), 32'h1);

    // Partial byte is discarded, next byte arrives intact
    doneBase = frameDoneCnt;
    frameBegin();
    applyStimulus(8'hFF, 5, 1'b0);
    frameEnd();
    checkOutput("partialCount", 32'(bus.Rx_Count), 32'd0);
    checkOutput("partialFrameDone", 32'(frameDoneCnt - doneBase), 32'd1);
    frameBegin();
    applyStimulus(8'h3C, 8, 1'b0);
    frameEnd();
    checkOutput("afterPartialCount", 32'(bus.Rx_Count), 32'd1);
    readByte("afterPartial", 8'h3C);

    // Fill and overflow: 17 bytes into a 16-deep FIFO
    frameBegin();
    for (int b = 0; b < 17; b++) applyStimulus(8'(b), 8, 1'b0);
    frameEnd();
    checkOutput("fillFull", 32'(bus.Rx_Full), 32'h1);
    checkOutput("fillOverflow", 32'(bus.Overflow), 32'h1);
    checkOutput("fillCount", 32'(bus.Rx_Count), 32'd16);
    for (int b = 0; b < 16; b++) readByte("fillRead", 8'(b));
    checkOutput("drainEmpty", 32'(bus.Rx_Empty), 32'h1);
    checkOutput("overflowSticky", 32'(bus.Overflow), 32'h1);
    bus.Ovf_Clr = 1'b1;
    @(negedge Mclk);
    bus.Ovf_Clr = 1'b0;
    checkOutput("ovfClr", 32'(bus.Overflow), 32'h0);

    // Full FIFO with a pop in the push cycle of 0x77
    frameBegin();
    for (int b = 0; b < 16; b++) applyStimulus(8'(8'h20 + b), 8, 1'b0);
    applyStimulus(8'h77, 8, 1'b1);
    frameEnd();
    checkOutput("fullPopNoOverflow", 32'(bus.Overflow), 32'h0);
    checkOutput("fullPopCountAfter", 32'(bus.Rx_Count), 32'd16);
    for (int b = 1; b < 16; b++) readByte("fullPopRead", 8'(8'h20 + b));
    readByte("fullPopLast", 8'h77);
    checkOutput("fullPopEmpty", 32'(bus.Rx_Empty), 32'h1);

    // Read from empty FIFO is ignored
    bus.Read_RQ = 1'b1;
    @(negedge Mclk);
    bus.Read_RQ = 1'b0;
    checkOutput("emptyReadValid", 32'(bus.Rx_Valid), 32'h0);
    checkOutput("emptyReadCount", 32'(bus.Rx_Count), 32'd0);
    checkOutput("emptyReadHold", 32'(bus.Rx_Data), 32'h77);
    frameBegin();
    applyStimulus(8'h5A, 8, 1'b0);
    frameEnd();
    readByte("emptyReadThen", 8'h5A);

    // Reset in the middle of a frame with three bytes buffered
    frameBegin();
    applyStimulus(8'h11, 8, 1'b0);
    applyStimulus(8'h22, 8, 1'b0);
    applyStimulus(8'h33, 8, 1'b0);
    applyStimulus(8'hF0, 4, 1'b0);
    checkOutput("preResetCount", 32'(bus.Rx_Count), 32'd3);
    nReset = 1'b0;
    #1;
    checkOutput("midRstCount", 32'(bus.Rx_Count), 32'd0);
    checkOutput("midRstEmpty", 32'(bus.Rx_Empty), 32'h1);
    checkOutput("midRstOverflow", 32'(bus.Overflow), 32'h0);
    checkOutput("midRstData", 32'(bus.Rx_Data), 32'h0);
    bus.SPI_CS  = 1'b1;
    bus.SPI_clk = 1'b0;
    repeat (3) @(negedge Mclk);
    nReset = 1'b1;
    repeat (10) @(negedge Mclk);
    checkOutput("postRstCount", 32'(bus.Rx_Count), 32'd0);
    frameBegin();
    applyStimulus(8'hC3, 8, 1'b0);
    frameEnd();
    checkOutput("postRstCountC3", 32'(bus.Rx_Count), 32'd1);
    readByte("postRst", 8'hC3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/spi_rx_deserializer.md
Name: spi_rx_deserializer

Overview:
- Receive-side companion to the SPI transmit path: samples SPI_MISO on the gated SPI clock during an active chip-select frame and assembles MSB-first bytes.
- Buffers completed bytes in an internal FIFO and hands them to the host one byte per Read_RQ.
- Runs entirely in the Mclk domain; SPI_clk, SPI_CS and SPI_MISO are treated as asynchronous inputs and synchronised internally.

Parameters:
- DEPTH, 16, RX FIFO depth in bytes (power of two)
- ADDR_W, 4, log2(DEPTH)
- SYNC_STAGES, 2, flip-flop stages on each SPI input

Ports:
- Mclk  in  1  system clock; all state changes on its rising edge
- nReset  in  1  asynchronous, active-low reset
- SPI_clk  in  1  gated SPI clock; idles low
- SPI_CS  in  1  chip select, active low
- SPI_MISO  in  1  serial data from the slave
- Read_RQ  in  1  host pop request, one byte per asserted cycle
- Ovf_Clr  in  1  clears Overflow
- Rx_Data  out  8  popped byte
- Rx_Valid  out  1  one-cycle strobe: Rx_Data is valid
- Rx_Empty  out  1  FIFO empty
- Rx_Full  out  1  FIFO holds DEPTH bytes
- Rx_Count  out  ADDR_W+1  bytes held
- Overflow  out  1  sticky: a completed byte was dropped
- Frame_Done  out  1  one-cycle pulse at the end of a CS frame

Behaviour:
- Reset: all outputs 0 except Rx_Empty=1. FIFO pointers, bit counter, shift register and synchronisers are cleared; the FSM goes to IDLE.
- Input conditioning:
  - SPI_clk, SPI_CS and SPI_MISO each pass through SYNC_STAGES flops with equal delay.
  - A rising-edge detector runs on the synchronised SPI_clk.
  - SPI_clk high and low phases are each at least 3 Mclk periods; slower inputs are outside the requirement.
- FSM, states IDLE and SHIFT:
  - IDLE -> SHIFT when synchronised CS is low. Entry clears the bit counter.
  - SHIFT -> IDLE when synchronised CS is high. Frame_Done pulses on the transition cycle.
  - A partial byte (bit counter != 0) is discarded on exit and is not pushed.
- Sampling:
  - In SHIFT, each detected rising SPI_clk edge shifts synchronised MISO into bit 0 (MSB first) and increments the 3-bit bit counter.
  - Sample point is SYNC_STAGES+1 Mclk cycles after the SPI_clk rise.
  - Edges seen in IDLE are ignored.
- Byte complete:
  - On the 8th sample the counter wraps to 0 and the full byte is pushed on the next Mclk edge.
  - Rx_Empty and Rx_Count update in the same cycle as the push.
- Push when full, no simultaneous pop: the byte is dropped, Overflow is set, and the FIFO is unchanged.
- Pop:
  - Read_RQ with Rx_Empty=0 registers the head byte onto Rx_Data and asserts Rx_Valid on the next cycle (latency 1).
  - Read_RQ with Rx_Empty=1 is ignored: no Rx_Valid, and Rx_Data holds its last value.
- Simultaneous push and pop:
  - Both are performed and Rx_Count is unchanged.
  - If the FIFO is full, the push is accepted because the pop frees a slot; no overflow occurs.
- Rx_Count is in 0..DEPTH. Pointers are ADDR_W bits and wrap modulo DEPTH.
- Rx_Full = (Rx_Count == DEPTH); Rx_Empty = (Rx_Count == 0).
- Overflow:
  - Cleared by Ovf_Clr.
  - If a set and Ovf_Clr occur in the same cycle, set wins.
- Frame boundary:
  - CS deasserting in the same cycle as the 8th sample: that byte is still pushed, then the FSM goes to IDLE.
  - Back-to-back frames with a CS high time of at least 2 Mclk cycles are each detected.
- Reset mid-frame: everything clears immediately, including buffered bytes; no partial byte survives.

Decomposition:
- Shared package: SPI state encoding (IDLE, SHIFT), the byte width constant (8) and the default FIFO depth constant. The TX FSM uses the same package.
- One natural sub-module, rx_fifo: synchronous FIFO with push, pop, count and full/empty, parameterised by DEPTH.
- Synchronisers, edge detect, FSM and shift register stay in the top.

Test Plan:
- Single byte: CS low, 8 SPI_clk pulses with MISO=1,0,1,0,0,1,0,1, CS high -> Rx_Count=1, Frame_Done pulse once; Read_RQ -> next cycle Rx_Valid=1, Rx_Data=0xA5, Rx_Empty=1.
- Partial byte: CS low, 5 clocks, CS high -> Rx_Count stays 0, Frame_Done pulses. The next full frame sending 0x3C reads back exactly 0x3C.
- Fill and overflow: send 17 bytes 0x00..0x10 with no reads -> Rx_Full=1, Overflow=1, Rx_Count=16. Reads return 0x00..0x0F in order, then Rx_Empty=1. Ovf_Clr clears Overflow.
- Full plus simultaneous pop: with 16 bytes held, assert Read_RQ in the push cycle of byte 0x77 -> Overflow stays 0, Rx_Count=16, and 0x77 is the last byte read.
- Empty read: Read_RQ with Rx_Empty=1 -> Rx_Valid stays 0, Rx_Count stays 0, no pointer movement.
- Reset mid-frame: deassert nReset after 4 clocks of a frame with 3 bytes buffered -> Rx_Count=0, Rx_Empty=1, Overflow=0 immediately. A following frame sending 0xC3 reads back 0xC3.
